cfg_write_arbiter: RTL and testbench
====================================

// Module: cfg_write_arbiter
// PURPOSE
//  Shares the single configuration-memory write port between NREQ password/confirm control units.
//  Each control unit raises req with its config word once it reaches its store state.
//  The block grants one requester at a time, round-robin, and drives the memory unit's wdata/waddr/we.
//  It returns a one-cycle done pulse to the granted requester.
//  Sits between the control units and the memory unit; the control units no longer drive write_en directly.
// PARAMETERS
//  NREQ      4   number of requesting control units (2..8)
//  CFG_W     35  configuration word width
//  WR_CYCLES 1   cycles mem_we is held per write (1..15)
// PORTS
//  clk        in   1           clock, posedge
//  arst       in   1           asynchronous reset, active-high
//  req        in   NREQ        level request per control unit; held until done/abandon
//  cfg_in     in   NREQ*CFG_W  config words; requester i at bits [i*CFG_W +: CFG_W]
//  grant      out  NREQ        one-hot, asserted for the whole write of the granted requester
//  done       out  NREQ        one-cycle pulse to requester i after its write completes
//  abort      out  1           one-cycle pulse when a granted requester drops req mid-write
//  mem_wdata  out  CFG_W       config word to memory unit (latched at grant)
//  mem_waddr  out  IDX_W       slot = granted requester index; IDX_W = $clog2(NREQ)
//  mem_we     out  1           memory write enable
//  busy       out  1           high in any state other than IDLE
//  dbg_state  out  2           current FSM state (debug)
// BEHAVIOUR
//  - Reset: arst high forces at once state=IDLE, ptr=0, and grant/done/abort/mem_we/busy=0.
//    It also clears mem_wdata and mem_waddr to 0. Reset mid-write drops mem_we with no done or abort.
//  - FSM states: IDLE=2'b00, WRITE=2'b01, DONE=2'b10, 2'b11 unused (returns to IDLE next cycle).
//  - IDLE: on a clock edge with |req, select winner w = first set bit scanning ptr, ptr+1, ... mod NREQ.
//    Latch mem_wdata=cfg_in[w], mem_waddr=w, grant=onehot(w), mem_we=1, wcnt=WR_CYCLES-1; go to WRITE.
//  - Grant latency: one cycle. req sampled at edge N gives grant/mem_we high after edge N.
//  - WRITE: mem_we and grant stay high. cfg_in changes are ignored, because the data is already latched.
//    If wcnt==0, go to DONE; otherwise decrement wcnt.
//    If req[w] is low at an edge in WRITE, drop grant and mem_we, pulse abort for 1 cycle, and go to IDLE.
//    In that case ptr=w+1, and no done is issued.
//  - DONE: grant=0, mem_we=0, done[w]=1 for exactly this cycle, ptr=(w+1) mod NREQ, then go to IDLE.
//    Back-to-back service: the next grant appears 2 cycles after done.
//  - Requester i must drop req in the cycle it sees done[i]. A req still high at the next IDLE edge counts as a new request.
//  - Simultaneous requests: only the winner is granted; losers keep req and are served in rotating order.
//    No requester waits more than NREQ-1 other writes.
//  - ptr wraps from NREQ-1 to 0. mem_we is never high in two consecutive writes without an intervening low cycle.
// CONFIGURATION
//  - Macro CFG_ARB_STATS_EN.
//  - Defined: adds outputs wr_count[15:0] and abort_count[15:0].
//    Both are reset to 0 by arst and saturate at 16'hFFFF.
//    wr_count increments on every done pulse; abort_count increments on every abort pulse.
//  - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package/include cfg_arb_defs.vh holds the FSM state encodings, CFG_W default, and the stats counter width.
//  - Sub-module rr_picker: combinational round-robin priority encoder.
//    Inputs req[NREQ], ptr[IDX_W]. Outputs valid and idx[IDX_W].
//    It is instantiated once; the FSM, latches, wcnt and ptr live in cfg_write_arbiter.
// TESTING
//  - Single request, NREQ=4, WR_CYCLES=1: req=4'b0100 with cfg_in[2]=35'h1_2345_6789.
//    Expect next cycle grant=4'b0100, mem_we=1, mem_waddr=2, mem_wdata=35'h1_2345_6789; then done[2]=1 for one cycle.
//  - All four requesting from reset (ptr=0): grants occur in order 0,1,2,3, each requester dropping req on its done.
//    Then raise req 0 and 3 together: ptr=0 after wrap, so 0 is granted before 3.
//  - WR_CYCLES=3: mem_we is high for exactly 3 consecutive cycles.
//    Changing cfg_in mid-write leaves mem_wdata unchanged.
//  - Abort: drop req[1] during WRITE with WR_CYCLES=3.
//    Expect abort=1 for one cycle, mem_we=0, done[1] never asserted, and ptr advances to 2.
//  - Reset mid-write: assert arst between clock edges while mem_we=1.
//    Expect all outputs 0 immediately and dbg_state=2'b00; after release with req held, a fresh grant follows one cycle later.
//  - With CFG_ARB_STATS_EN: 5 completed writes and 2 aborts give wr_count=5 and abort_count=2.
//    Forcing the count to 16'hFFFF holds it at 16'hFFFF.

Source files
------------

// File: rtl/cfg_write_arbiter_pkg.sv
// Shared definitions for the configuration-memory write arbiter:
// FSM encodings, default word width, stats counter width and pointer wrap helper.
package cfg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WRITE  = 2'b01,
        ST_DONE   = 2'b10,
        ST_UNUSED = 2'b11
    } arb_state_e;

    localparam int CFG_W_DEFAULT = 35;
    localparam int STATS_W       = 16;
    localparam int WCNT_W        = 4;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cfg_write_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request bit
// scanning upward from ptr, wrapping modulo NREQ.
module rr_picker
    import cfg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] j;

    // Scan from the farthest slot back to ptr so the closest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Round-robin arbiter sharing the config-memory write port between NREQ control units.
// Optional write/abort statistics counters are enabled with macro CFG_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | no write in progress; grant the next requester on any req
// WRITE  | mem_we/grant held for WR_CYCLES cycles; req drop aborts
// DONE   | one-cycle done pulse to the served requester
// UNUSED | illegal encoding; falls back to IDLE
module cfg_write_arbiter
    import cfg_write_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int CFG_W     = CFG_W_DEFAULT,
    parameter int WR_CYCLES = 1,
    localparam int IDX_W    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CFG_W-1:0] cfg_in,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  abort,
    output logic [CFG_W-1:0]      mem_wdata,
    output logic [IDX_W-1:0]      mem_waddr,
    output logic                  mem_we,
    output logic                  busy,
    output logic [1:0]            dbg_state
`ifdef CFG_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]    wr_count,
    output logic [STATS_W-1:0]    abort_count
`endif
);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   done_q;
    logic              abort_q;
    logic              mem_we_q;
    logic [CFG_W-1:0]  mem_wdata_q;
    logic [IDX_W-1:0]  mem_waddr_q;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [CFG_W-1:0]  pick_word;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_word = cfg_in[i*CFG_W +: CFG_W];
            end
        end
    end

    // mem_waddr_q doubles as the index of the requester being served.
    assign ptr_d = IDX_W'(wrap_inc(int'(mem_waddr_q), NREQ));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            wcnt_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            abort_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_waddr_q <= '0;
        end else begin
            done_q  <= '0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        mem_wdata_q <= pick_word;
                        mem_waddr_q <= pick_idx;
                        grant_q     <= NREQ'(1) << pick_idx;
                        mem_we_q    <= 1'b1;
                        wcnt_q      <= WCNT_W'(WR_CYCLES - 1);
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!req[mem_waddr_q]) begin
                        grant_q  <= '0;
                        mem_we_q <= 1'b0;
                        abort_q  <= 1'b1;
                        ptr_q    <= ptr_d;
                        state_q  <= ST_IDLE;
                    end else if (wcnt_q == '0) begin
                        grant_q              <= '0;
                        mem_we_q             <= 1'b0;
                        done_q[mem_waddr_q]  <= 1'b1;
                        ptr_q                <= ptr_d;
                        state_q              <= ST_DONE;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q  <= '0;
                    mem_we_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_waddr = mem_waddr_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

`ifdef CFG_ARB_STATS_EN
    logic               wr_evt;
    logic               ab_evt;
    logic [STATS_W-1:0] wr_count_q;
    logic [STATS_W-1:0] wr_count_d;
    logic [STATS_W-1:0] abort_count_q;
    logic [STATS_W-1:0] abort_count_d;

    // Counters step on the same edge that raises done/abort, so they track the pulses.
    assign ab_evt = (state_q == ST_WRITE) && !req[mem_waddr_q];
    assign wr_evt = (state_q == ST_WRITE) && req[mem_waddr_q] && (wcnt_q == '0);

    assign wr_count_d    = (wr_evt && wr_count_q != '1) ? wr_count_q + 1'b1 : wr_count_q;
    assign abort_count_d = (ab_evt && abort_count_q != '1) ? abort_count_q + 1'b1 : abort_count_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_count_q    <= '0;
            abort_count_q <= '0;
        end else begin
            wr_count_q    <= wr_count_d;
            abort_count_q <= abort_count_d;
        end
    end

    assign wr_count    = wr_count_q;
    assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: two instances (WR_CYCLES=1 and 3) checked against
// a transaction-level model every cycle, plus directed literal expectations.
module tb_cfg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int CFG_W = 35;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req_v   [2];
    logic [NREQ*CFG_W-1:0] cfg_v   [2];
    logic [NREQ-1:0]       grant_v [2];
    logic [NREQ-1:0]       done_v  [2];
    logic                  abort_v [2];
    logic                  we_v    [2];
    logic                  busy_v  [2];
    logic [CFG_W-1:0]      wdata_v [2];
    logic [1:0]            waddr_v [2];
    logic [1:0]            dbg_v   [2];
`ifdef CFG_ARB_STATS_EN
    logic [15:0]           wrc_v   [2];
    logic [15:0]           abc_v   [2];
`endif

    int errors = 0;
    int checks = 0;

    cfg_write_arbiter #(.NREQ(NREQ), .CFG_W(CFG_W), .WR_CYCLES(1)) u_arb1 (
        .clk(clk), .arst(arst), .req(req_v[0]), .cfg_in(cfg_v[0]),
        .grant(grant_v[0]), .done(done_v[0]), .abort(abort_v[0]),
        .mem_wdata(wdata_v[0]), .mem_waddr(waddr_v[0]), .mem_we(we_v[0]),
        .busy(busy_v[0]), .dbg_state(dbg_v[0])
`ifdef CFG_ARB_STATS_EN
        , .wr_count(wrc_v[0]), .abort_count(abc_v[0])
`endif
    );

    cfg_write_arbiter #(.NREQ(NREQ), .CFG_W(CFG_W), .WR_CYCLES(3)) u_arb3 (
        .clk(clk), .arst(arst), .req(req_v[1]), .cfg_in(cfg_v[1]),
        .grant(grant_v[1]), .done(done_v[1]), .abort(abort_v[1]),
        .mem_wdata(wdata_v[1]), .mem_waddr(waddr_v[1]), .mem_we(we_v[1]),
        .busy(busy_v[1]), .dbg_state(dbg_v[1])
`ifdef CFG_ARB_STATS_EN
        , .wr_count(wrc_v[1]), .abort_count(abc_v[1])
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    // phase: 0 idle, 1..WR = k-th cycle of the write, -1 = done cycle
    int               m_phase [2] = '{0, 0};
    int               m_w     [2] = '{0, 0};
    int               m_ptr   [2] = '{0, 0};
    logic [CFG_W-1:0] m_word  [2] = '{'0, '0};
    logic             m_abort [2] = '{1'b0, 1'b0};
    int               m_wr    [2] = '{0, 0};
    int               m_ab    [2] = '{0, 0};

    function automatic int wr_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        logic [1:0] j;
        for (int k = 0; k < NREQ; k++) begin
            j = 2'((p + k) % NREQ);
            if (r[j]) return int'(j);
        end
        return 0;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_w[i] = 0; m_ptr[i] = 0; m_word[i] = '0;
                m_abort[i] = 1'b0; m_wr[i] = 0; m_ab[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_abort[i] = 1'b0;
                if (m_phase[i] == 0) begin
                    if (req_v[i] != '0) begin
                        m_w[i]     = pick(req_v[i], m_ptr[i]);
                        m_word[i]  = CFG_W'(cfg_v[i] >> (m_w[i] * CFG_W));
                        m_phase[i] = 1;
                    end
                end else if (m_phase[i] < 0) begin
                    m_phase[i] = 0;
                end else if (!req_v[i][m_w[i][1:0]]) begin
                    m_abort[i] = 1'b1;
                    m_ptr[i]   = (m_w[i] + 1) % NREQ;
                    m_phase[i] = 0;
                    if (m_ab[i] < 65535) m_ab[i]++;
                end else if (m_phase[i] == wr_of(i)) begin
                    m_phase[i] = -1;
                    m_ptr[i]   = (m_w[i] + 1) % NREQ;
                    if (m_wr[i] < 65535) m_wr[i]++;
                end else begin
                    m_phase[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (arst === 1'b0) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("grant[%0d]", i), 64'(grant_v[i]),
                      (m_phase[i] > 0) ? 64'(4'b0001 << m_w[i]) : 64'd0);
                check($sformatf("done[%0d]", i), 64'(done_v[i]),
                      (m_phase[i] < 0) ? 64'(4'b0001 << m_w[i]) : 64'd0);
                check($sformatf("mem_we[%0d]", i), 64'(we_v[i]), 64'(m_phase[i] > 0));
                check($sformatf("abort[%0d]", i), 64'(abort_v[i]), 64'(m_abort[i]));
                check($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(m_phase[i] != 0));
                check($sformatf("dbg_state[%0d]", i), 64'(dbg_v[i]),
                      (m_phase[i] == 0) ? 64'd0 : ((m_phase[i] > 0) ? 64'd1 : 64'd2));
                check($sformatf("mem_waddr[%0d]", i), 64'(waddr_v[i]), 64'(m_w[i]));
                check($sformatf("mem_wdata[%0d]", i), 64'(wdata_v[i]), 64'(m_word[i]));
`ifdef CFG_ARB_STATS_EN
                check($sformatf("wr_count[%0d]", i), 64'(wrc_v[i]), 64'(m_wr[i]));
                check($sformatf("abort_count[%0d]", i), 64'(abc_v[i]), 64'(m_ab[i]));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #2 arst = 1'b1;
        @(posedge clk); #2 arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int i, output int idx);
        idx = -1;
        for (int n = 0; n < 60 && idx < 0; n++) begin
            @(negedge clk);
            for (int b = 0; b < NREQ; b++) if (done_v[i][b]) idx = b;
        end
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout[%0d]: got=none expected=done pulse", i);
        end else begin
            req_v[i][idx] = 1'b0;
        end
    endtask

    task automatic wait_we(input int i);
        int n;
        @(negedge clk);
        n = 1;
        while (!we_v[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!we_v[i]) begin
            checks++; errors++;
            $display("FAIL we_timeout[%0d]: got=0 expected=1", i);
        end
    endtask

    int idx;
    int cnt;
    logic saw;
    int exp_ord [3] = '{3, 0, 1};

    initial begin
        req_v[0] = '0; req_v[1] = '0;
        cfg_v[0] = '0; cfg_v[1] = '0;
        #1 arst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_grant", 64'(grant_v[i]), 64'd0);
            check("rst_we", 64'(we_v[i]), 64'd0);
            check("rst_busy", 64'(busy_v[i]), 64'd0);
            check("rst_dbg", 64'(dbg_v[i]), 64'd0);
            check("rst_wdata", 64'(wdata_v[i]), 64'd0);
        end
        @(posedge clk); #2 arst = 1'b0;
        @(negedge clk);

        // single request, WR_CYCLES=1
        cfg_v[0][2*CFG_W +: CFG_W] = 35'h1_2345_6789;
        req_v[0] = 4'b0100;
        @(posedge clk); #1;
        check("single_grant", 64'(grant_v[0]), 64'h4);
        check("single_we", 64'(we_v[0]), 64'd1);
        check("single_waddr", 64'(waddr_v[0]), 64'd2);
        check("single_wdata", 64'(wdata_v[0]), 64'h1_2345_6789);
        wait_done(0, idx);
        check("single_done_idx", 64'(idx), 64'd2);
        @(negedge clk);
        check("single_done_one_cycle", 64'(done_v[0]), 64'd0);

        // all four from reset: rotation 0,1,2,3 then 0 before 3
        do_reset();
        cfg_v[0] = {35'h3_0303_0303, 35'h2_0202_0202, 35'h1_0101_0101, 35'h0_0F0F_0F0F};
        req_v[0] = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(0, idx);
            check($sformatf("rr_order_%0d", k), 64'(idx), 64'(k));
        end
        @(negedge clk);
        req_v[0] = 4'b1001;
        wait_done(0, idx);
        check("wrap_first", 64'(idx), 64'd0);
        wait_done(0, idx);
        check("wrap_second", 64'(idx), 64'd3);

        // WR_CYCLES=3: mem_we length and latched data
        @(negedge clk);
        cfg_v[1][0 +: CFG_W] = 35'h0_AAAA_5555;
        req_v[1] = 4'b0001;
        wait_we(1);
        cnt = 0;
        while (we_v[1] && cnt < 20) begin
            cnt++;
            if (cnt == 2) cfg_v[1][0 +: CFG_W] = 35'h7_FFFF_0000;
            check("latched_wdata", 64'(wdata_v[1]), 64'h0_AAAA_5555);
            @(negedge clk);
        end
        check("we_len", 64'(cnt), 64'd3);
        check("wr3_done", 64'(done_v[1]), 64'h1);
        req_v[1] = '0;

        // abort of requester 1 mid-write
        @(negedge clk);
        req_v[1] = 4'b0010;
        wait_we(1);
        @(negedge clk);
        req_v[1][1] = 1'b0;
        @(negedge clk);
        check("abort_pulse", 64'(abort_v[1]), 64'd1);
        check("abort_we", 64'(we_v[1]), 64'd0);
        check("abort_grant", 64'(grant_v[1]), 64'd0);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done_v[1][1]) saw = 1'b1;
        end
        check("abort_no_done", 64'(saw), 64'd0);
        req_v[1] = 4'b1011;
        wait_we(1);
        check("abort_ptr_grant", 64'(grant_v[1]), 64'h8);
        for (int k = 0; k < 3; k++) begin
            wait_done(1, idx);
            check($sformatf("after_abort_order_%0d", k), 64'(idx), 64'(exp_ord[k]));
        end

        // reset in the middle of a write
        @(negedge clk);
        cfg_v[1][2*CFG_W +: CFG_W] = 35'h5_0505_0505;
        req_v[1] = 4'b0100;
        wait_we(1);
        @(posedge clk); #2 arst = 1'b1;
        #1;
        check("mid_rst_grant", 64'(grant_v[1]), 64'd0);
        check("mid_rst_we", 64'(we_v[1]), 64'd0);
        check("mid_rst_busy", 64'(busy_v[1]), 64'd0);
        check("mid_rst_dbg", 64'(dbg_v[1]), 64'd0);
        check("mid_rst_waddr", 64'(waddr_v[1]), 64'd0);
        check("mid_rst_wdata", 64'(wdata_v[1]), 64'd0);
        check("mid_rst_done", 64'(done_v[1]), 64'd0);
        check("mid_rst_abort", 64'(abort_v[1]), 64'd0);
        #4 arst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_grant", 64'(grant_v[1]), 64'h4);
        check("post_rst_we", 64'(we_v[1]), 64'd1);
        check("post_rst_wdata", 64'(wdata_v[1]), 64'h5_0505_0505);
        wait_done(1, idx);
        check("post_rst_done_idx", 64'(idx), 64'd2);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
